// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and frame-length helper for piso_serializer
// SER_PARITY_EN adds one even-parity bit to each frame.
package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   function automatic int ser_flen(input int width);
`ifdef SER_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - bit-position counter for one serial frame
// The counter wraps to 0 after the last bit so an idle serializer always sits at 0.
module ser_bit_counter #(
   parameter int FLEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic term
);

   localparam int CW = $clog2(FLEN + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc) begin
         if (term) cnt <= '0;
         else      cnt <= cnt + 1'b1;
      end
   end

   assign term = (cnt == CW'(FLEN - 1));

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - valid/ready word in, LSB-first serial bit stream out
// SER_PARITY_EN appends an even-parity bit after the WIDTH data bits.
module piso_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             sof
);

   localparam int FLEN = ser_flen(WIDTH);

   ser_state_t      state;
   logic [FLEN-1:0] sr;
   logic [FLEN-1:0] frame;
   logic            term;
   logic            xfer;

   // Parity rides in the top bit of the shift register, so it falls out after the data.
`ifdef SER_PARITY_EN
   assign frame = {^in_data, in_data};
`else
   assign frame = in_data;
`endif

   assign in_ready = (state == IDLE) || (state == SHIFT && term);
   assign xfer     = in_valid && in_ready;
   assign dout     = sr[0];

   ser_bit_counter #(
      .FLEN (FLEN)
   ) u_bit_counter (
      .clk   (clk),
      .rst   (rst),
      .clear (xfer),
      .inc   (state == SHIFT),
      .term  (term)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         sr         <= '0;
         dout_valid <= 1'b0;
         sof        <= 1'b0;
      end else if (xfer) begin
         state      <= SHIFT;
         sr         <= frame;
         dout_valid <= 1'b1;
         sof        <= 1'b1;
      end else begin
         case (state)
            SHIFT: begin
               sof <= 1'b0;
               if (term) begin
                  state      <= IDLE;
                  sr         <= '0;
                  dout_valid <= 1'b0;
               end else begin
                  sr <= sr >> 1;
               end
            end
            default: begin
               sr         <= '0;
               dout_valid <= 1'b0;
               sof        <= 1'b0;
            end
         endcase
      end
   end

endmodule
